// File: rtl/router_fsm.sv
// Packet-level control FSM for the 1x3 router: decodes the header address,
// sequences header/payload/parity/full-stall phases, drives the register
// block's load strobes and FIFO write request, and stalls the source via busy.
module router_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty0,
  input  logic       fifo_empty1,
  input  logic       fifo_empty2,
  input  logic       soft_rst0,
  input  logic       soft_rst1,
  input  logic       soft_rst2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_en_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] addr_q;
  logic [1:0] sel_addr;
  logic       empty_sel;
  logic       soft_sel;

  // Pick one of the three per-port flags; address 3 has no port and reads 0.
  function automatic logic pick_port(input logic [1:0] a,
                                     input logic       p0,
                                     input logic       p1,
                                     input logic       p2);
    logic r;
    case (a)
      2'd0:    r = p0;
      2'd1:    r = p1;
      2'd2:    r = p2;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // While decoding, the header is on data_in; afterwards the latched address rules.
  always_comb begin
    sel_addr  = (state_q == DECODE_ADDRESS) ? data_in : addr_q;
    empty_sel = pick_port(sel_addr, fifo_empty0, fifo_empty1, fifo_empty2);
    soft_sel  = pick_port(addr_q, soft_rst0, soft_rst1, soft_rst2);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DECODE_ADDRESS;
    else      state_q <= state_d;
  end

  // Destination address captured with the header and held for the packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          addr_q <= 2'b00;
    else if (state_q == DECODE_ADDRESS && pkt_valid)   addr_q <= data_in;
  end

  // Next-state logic; a soft reset on the addressed port aborts the packet.
  always_comb begin
    state_d = state_q;
    if (state_q != DECODE_ADDRESS && soft_sel) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid && data_in != 2'd3)
            state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (empty_sel) state_d = LOAD_FIRST_DATA;
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore outputs decoded purely from the registered state.
  always_comb begin
    detect_add   = (state_q == DECODE_ADDRESS);
    lfd_state    = (state_q == LOAD_FIRST_DATA);
    ld_state     = (state_q == LOAD_DATA);
    laf_state    = (state_q == LOAD_AFTER_FULL);
    full_state   = (state_q == FIFO_FULL_STATE);
    rst_int_reg  = (state_q == CHECK_PARITY_ERROR);
    write_en_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                   (state_q == LOAD_AFTER_FULL);
    busy         = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: stimulus pushes the expected output vector
// for each cycle, a monitor pops and compares against the DUT outputs.
module tb_router_fsm;

  logic       clk;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty0, fifo_empty1, fifo_empty2;
  logic       soft_rst0, soft_rst1, soft_rst2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_en_reg, rst_int_reg, busy;

  // Output vector order:
  // {detect_add, lfd_state, ld_state, laf_state, full_state, write_en_reg, rst_int_reg, busy}
  localparam logic [7:0] S_DA   = 8'b1000_0000;
  localparam logic [7:0] S_LFD  = 8'b0100_0001;
  localparam logic [7:0] S_LD   = 8'b0010_0100;
  localparam logic [7:0] S_LAF  = 8'b0001_0101;
  localparam logic [7:0] S_FULL = 8'b0000_1001;
  localparam logic [7:0] S_LP   = 8'b0000_0101;
  localparam logic [7:0] S_CPE  = 8'b0000_0011;
  localparam logic [7:0] S_WTE  = 8'b0000_0001;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  event     chk_ev;
  int       n_cmp;
  int       n_bad;
  logic     done;

  router_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty0  (fifo_empty0),
    .fifo_empty1  (fifo_empty1),
    .fifo_empty2  (fifo_empty2),
    .soft_rst0    (soft_rst0),
    .soft_rst1    (soft_rst1),
    .soft_rst2    (soft_rst2),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .write_en_reg (write_en_reg),
    .rst_int_reg  (rst_int_reg),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input logic [7:0] e, input string nm);
    sb_item_t it;
    it.name = nm;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  // Apply current inputs across one rising edge, then post the expected outputs.
  task automatic step(input logic [7:0] e, input string nm);
    @(posedge clk);
    #1;
    push(e, nm);
  endtask

  task automatic idle();
    pkt_valid     = 1'b0;
    data_in       = 2'd0;
    fifo_full     = 1'b0;
    fifo_empty0   = 1'b1;
    fifo_empty1   = 1'b1;
    fifo_empty2   = 1'b1;
    soft_rst0     = 1'b0;
    soft_rst1     = 1'b0;
    soft_rst2     = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
  endtask

  // Monitor: compares on every falling edge, or immediately on chk_ev.
  initial begin
    sb_item_t   it;
    logic [7:0] got;
    n_cmp = 0;
    n_bad = 0;
    forever begin
      @(negedge clk or chk_ev);
      if (done) begin
        n_cmp++;
        if (sb_q.size() != 0) begin
          n_bad++;
          $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      if (sb_q.size() != 0) begin
        it  = sb_q.pop_front();
        got = {detect_add, lfd_state, ld_state, laf_state, full_state,
               write_en_reg, rst_int_reg, busy};
        n_cmp++;
        if (got !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got %b required %b at %0t", it.name, got, it.exp, $time);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    done = 1'b0;
    rst  = 1'b0;
    idle();

    // Reset holds DECODE_ADDRESS even with a valid header present.
    pkt_valid = 1'b1; data_in = 2'd1;
    step(S_DA, "reset_0");
    step(S_DA, "reset_1");
    rst = 1'b1; idle();
    step(S_DA, "reset_release");

    // Packet to port 1, FIFO1 empty, 4 payload cycles.
    pkt_valid = 1'b1; data_in = 2'd1;
    step(S_LFD, "p1_lfd");
    data_in = 2'd0;
    step(S_LD,  "p1_ld1");
    step(S_LD,  "p1_ld2");
    step(S_LD,  "p1_ld3");
    step(S_LD,  "p1_ld4");
    pkt_valid = 1'b0;
    step(S_LP,  "p1_parity");
    step(S_CPE, "p1_check");
    step(S_DA,  "p1_done");
    step(S_DA,  "p1_idle");

    // Port 2 with FIFO2 non-empty for 6 cycles; data_in changed to prove addr_q is used.
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty2 = 1'b0;
    step(S_WTE, "p2_wte1");
    data_in = 2'd0;
    for (int i = 2; i <= 6; i++) step(S_WTE, $sformatf("p2_wte%0d", i));
    fifo_empty2 = 1'b1;
    step(S_LFD, "p2_lfd");
    step(S_LD,  "p2_ld");

    // Full stall for 3 cycles, then resume payload.
    fifo_full = 1'b1;
    step(S_FULL, "full1");
    step(S_FULL, "full2");
    step(S_FULL, "full3");
    fifo_full = 1'b0;
    step(S_LAF, "laf_resume");
    step(S_LD,  "laf_to_ld");

    // Full and end-of-packet together: full wins, parity via low_pkt_valid.
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step(S_FULL, "full_wins");
    fifo_full = 1'b0;
    step(S_LAF, "laf_low");
    low_pkt_valid = 1'b1;
    step(S_LP,  "laf_to_lp");
    low_pkt_valid = 1'b0;
    step(S_CPE, "lp_to_cpe");
    fifo_full = 1'b1;
    step(S_FULL, "cpe_full");
    fifo_full = 1'b0;
    step(S_LAF, "laf_pd");
    parity_done = 1'b1; low_pkt_valid = 1'b1;
    step(S_DA,  "laf_parity_done");
    idle();

    // Address 3 is dropped.
    pkt_valid = 1'b1; data_in = 2'd3;
    for (int i = 0; i < 5; i++) step(S_DA, $sformatf("addr3_%0d", i));
    idle();

    // Port 0: soft reset is ignored in DECODE_ADDRESS and for other ports.
    pkt_valid = 1'b1; data_in = 2'd0; soft_rst0 = 1'b1;
    step(S_LFD, "p0_lfd_sr_in_da");
    soft_rst0 = 1'b0;
    step(S_LD,  "p0_ld");
    soft_rst1 = 1'b1; soft_rst2 = 1'b1;
    step(S_LD,  "p0_other_sr");
    soft_rst1 = 1'b0; soft_rst2 = 1'b0; soft_rst0 = 1'b1;
    step(S_DA,  "p0_soft_rst");
    idle();

    // Soft reset aborts WAIT_TILL_EMPTY on port 2.
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty2 = 1'b0;
    step(S_WTE, "p2_wte_sr");
    soft_rst2 = 1'b1;
    step(S_DA,  "p2_wte_abort");
    idle();

    // Async reset mid-packet takes effect without a clock edge.
    pkt_valid = 1'b1; data_in = 2'd0;
    step(S_LFD, "p0b_lfd");
    step(S_LD,  "p0b_ld");
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    push(S_DA, "async_rst");
    -> chk_ev;
    data_in = 2'd1;
    step(S_DA, "rst_hold");
    rst = 1'b1; idle();
    step(S_DA, "post_rst");

    @(negedge clk);
    #1;
    done = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL monitor_timeout: summary not reached, required within 10 cycles");
    $fatal(1, "monitor did not terminate");
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Packet-level control FSM for the 1x3 router. It sits between the input port and the register, synchronizer and FIFO blocks.
- Decodes the 2-bit destination address in each header.
- Sequences header, payload, parity and full-stall phases.
- Drives the register block's load strobes and write-enable request.
- Asserts busy to stall the source.
- Aborts a packet when the addressed output's soft reset fires.

Parameters:
None; the three destinations and the 2-bit address are fixed by the router architecture.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
pkt_valid  in  1  source has a valid byte; deasserts after last payload byte
data_in  in  2  header address bits [1:0], sampled in DECODE_ADDRESS
fifo_full  in  1  addressed FIFO full (from synchronizer)
fifo_empty0/1/2  in  1 each  per-output FIFO empty
soft_rst0/1/2  in  1 each  per-output soft reset (from synchronizer)
parity_done  in  1  register block has loaded the parity byte
low_pkt_valid  in  1  register block saw pkt_valid fall while stalled
detect_add  out  1  state is DECODE_ADDRESS
lfd_state  out  1  state is LOAD_FIRST_DATA
ld_state  out  1  state is LOAD_DATA
laf_state  out  1  state is LOAD_AFTER_FULL
full_state  out  1  state is FIFO_FULL_STATE
write_en_reg  out  1  request FIFO write (LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL)
rst_int_reg  out  1  state is CHECK_PARITY_ERROR
busy  out  1  stall source; high in every state except DECODE_ADDRESS and LOAD_DATA

Behaviour:
- Reset (rst=0, async): state DECODE_ADDRESS, addr_q=2'b00. Outputs: detect_add=1, all other outputs 0.
- All outputs are Moore, decoded from the registered state, with no combinational input-to-output path. State changes one cycle after the enabling condition.
- addr_q latches data_in on the clock edge where state=DECODE_ADDRESS and pkt_valid=1, and holds for the rest of the packet.
- empty_sel = fifo_empty[data_in] in DECODE_ADDRESS; fifo_empty[addr_q] elsewhere.
- DECODE_ADDRESS:
  - pkt_valid=1, data_in!=3, empty_sel=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, data_in!=3, empty_sel=0 -> WAIT_TILL_EMPTY.
  - data_in=3 or pkt_valid=0 -> stay. Address 3 is dropped; busy stays 0.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (one cycle).
- LOAD_DATA (priority order):
  - fifo_full=1 -> FIFO_FULL_STATE.
  - else pkt_valid=0 -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL (priority order):
  - parity_done=1 -> DECODE_ADDRESS.
  - else low_pkt_valid=1 -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: empty_sel=1 -> LOAD_FIRST_DATA; else stay.
- Soft reset: if soft_rst[addr_q]=1 in any state other than DECODE_ADDRESS, next state is DECODE_ADDRESS. This overrides all other transitions. soft_rst of non-addressed ports is ignored.
- Illegal or unreachable state encodings -> DECODE_ADDRESS on the next edge.
- Simultaneous fifo_full=1 and pkt_valid=0 in LOAD_DATA: full wins; parity is handled via LOAD_AFTER_FULL with low_pkt_valid.
- Reset asserted mid-packet: immediate return to reset values; addr_q cleared.

Test Plan:
- Packet to port 1, FIFO1 empty: pkt_valid=1, data_in=01, 4 payload cycles, then pkt_valid=0 -> states DECODE, LFD, LD x4, LOAD_PARITY, CHECK_PARITY, DECODE. busy=1 in LFD, parity and check states. write_en_reg=1 for 5 cycles.
- Header to port 2 with fifo_empty2=0 for 6 cycles -> WAIT_TILL_EMPTY with busy=1 for 6 cycles. LOAD_FIRST_DATA on the cycle after fifo_empty2 rises.
- fifo_full=1 for 3 cycles during LOAD_DATA -> FIFO_FULL_STATE x3, full_state=1, busy=1, write_en_reg=0. Then LOAD_AFTER_FULL, and back to LOAD_DATA with parity_done=0, low_pkt_valid=0.
- Full stall with low_pkt_valid=1 on exit -> LAF, LOAD_PARITY, CHECK_PARITY. Repeat with parity_done=1 -> LAF, DECODE.
- data_in=11, pkt_valid=1 for 5 cycles -> stays DECODE_ADDRESS, detect_add=1, busy=0 throughout.
- Packet to port 0 in LOAD_DATA:
  - soft_rst0=1 -> DECODE_ADDRESS next cycle.
  - soft_rst1=1 instead -> no effect.
  - rst low mid-packet -> detect_add=1 and busy=0 without waiting for a clock edge.
